spi_master_arbiter: RTL and testbench

//  Shares one spi_master_rtl among NREQ requesters (sequencers, CPU port, test agents).

---
 rtl/spi_master_arbiter.sv | 136 +++++++++++++
 tb/tb_spi_master_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// Handles the send/busy handshake with a send timeout and returns the received word to the winner.
module spi_master_arbiter #(
  parameter int NREQ    = 3,
  parameter int BITS    = 20,
  parameter int SSW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*SSW-1:0]  i_req_ss,
  input  logic [NREQ*BITS-1:0] i_req_data,
  output logic [NREQ-1:0]      o_ack,
  output logic [NREQ-1:0]      o_done,
  output logic [NREQ-1:0]      o_err,
  output logic [BITS-1:0]      o_rdata,
  output logic [2:0]           o_grant_id,
  output logic                 o_active,
  output logic                 o_m_send,
  output logic [SSW-1:0]       o_m_slave_select,
  output logic [BITS-1:0]      o_m_data,
  input  logic [BITS-1:0]      i_m_data,
  input  logic                 i_m_busy
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [2:0]      ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt_oh;

  logic            found;
  logic [2:0]      win;
  logic [NREQ-1:0] win_oh;
  logic [SSW-1:0]  win_ss;
  logic [BITS-1:0] win_data;
  logic [3:0]      idx;

  // Scan ptr, ptr+1, ... with wrap; first requester found wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    win_ss   = '0;
    win_data = '0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && i_req[j] && idx == 4'(j)) begin
          found     = 1'b1;
          win       = 3'(j);
          win_oh[j] = 1'b1;
          win_ss    = i_req_ss[j*SSW +: SSW];
          win_data  = i_req_data[j*BITS +: BITS];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state            <= S_IDLE;
      ptr              <= '0;
      cnt              <= '0;
      gnt_oh           <= '0;
      o_ack            <= '0;
      o_done           <= '0;
      o_err            <= '0;
      o_rdata          <= '0;
      o_grant_id       <= '0;
      o_active         <= 1'b0;
      o_m_send         <= 1'b0;
      o_m_slave_select <= '0;
      o_m_data         <= '0;
    end else begin
      o_ack  <= '0;
      o_done <= '0;
      o_err  <= '0;
      case (state)
        S_IDLE: begin
          if (!i_m_busy && found) begin
            o_ack      <= win_oh;
            o_grant_id <= win;
            gnt_oh     <= win_oh;
            ptr        <= (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
            // Slave 0 means "no slave": reject without touching the master.
            if (win_ss == '0) begin
              o_err <= win_oh;
            end else begin
              o_m_slave_select <= win_ss;
              o_m_data         <= win_data;
              o_m_send         <= 1'b1;
              o_active         <= 1'b1;
              cnt              <= '0;
              state            <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (i_m_busy) begin
            o_m_send <= 1'b0;
            cnt      <= '0;
            state    <= S_WAIT;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            o_m_send <= 1'b0;
            o_err    <= gnt_oh;
            o_active <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!i_m_busy) begin
            o_rdata  <= i_m_data;
            o_done   <= gnt_oh;
            o_active <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter; the SPI master's busy/data side is driven from tasks.
module tb_spi_master_arbiter;
  localparam int NREQ = 3, BITS = 20, SSW = 3, TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SSW-1:0]  req_ss;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ-1:0]      ack, done, err;
  logic [BITS-1:0]      rdata;
  logic [2:0]           grant_id;
  logic                 active, m_send;
  logic [SSW-1:0]       m_ss;
  logic [BITS-1:0]      m_dout;
  logic [BITS-1:0]      m_din;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;
  int waited;
  int hi;

  spi_master_arbiter #(.NREQ(NREQ), .BITS(BITS), .SSW(SSW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_ss(req_ss), .i_req_data(req_data),
    .o_ack(ack), .o_done(done), .o_err(err), .o_rdata(rdata), .o_grant_id(grant_id),
    .o_active(active), .o_m_send(m_send), .o_m_slave_select(m_ss), .o_m_data(m_dout),
    .i_m_data(m_din), .i_m_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ack == '0 && w < 20);
  endtask

  // One full transfer for requester k: ack, busy handshake, reply, done.
  task automatic serve(input int k, input logic [2:0] ss, input logic [19:0] data,
                       input logic [19:0] reply, input bit drop, output int w);
    wait_ack(w);
    check("ack", 32'(ack), 32'(1 << k));
    check("grant_id", 32'(grant_id), 32'(k));
    check("send_on_ack", 32'(m_send), 32'd1);
    check("m_ss", 32'(m_ss), 32'(ss));
    check("m_data", 32'(m_dout), 32'(data));
    if (drop) req = '0;
    busy = 1'b1;
    @(negedge clk);
    check("send_off", 32'(m_send), 32'd0);
    check("active_wait", 32'(active), 32'd1);
    repeat (3) @(negedge clk);
    check("hold_data", 32'(m_dout), 32'(data));
    m_din = reply;
    busy  = 1'b0;
    @(negedge clk);
    check("done", 32'(done), 32'(1 << k));
    check("no_err_with_done", 32'(err), 32'd0);
    check("rdata", 32'(rdata), 32'(reply));
    check("active_off", 32'(active), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = '0; req_ss = '0; req_data = '0; m_din = '0; busy = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_send", 32'(m_send), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: single request from requester 1 to slave 2
    req_ss   = {3'd0, 3'd2, 3'd0};
    req_data = {20'h0, 20'hA5A5A, 20'h0};
    req      = 3'b010;
    serve(1, 3'd2, 20'hA5A5A, 20'h5A5A5, 1'b1, waited);
    check("t1_ack_latency", 32'(waited), 32'd1);
    @(negedge clk);
    check("t1_ss_hold", 32'(m_ss), 32'd2);

    // 3: ss==0 reject from requester 2 (ptr is 2 here)
    req_ss = {3'd0, 3'd2, 3'd1};
    req    = 3'b100;
    @(negedge clk);
    check("t3_ack", 32'(ack), 32'b100);
    check("t3_err", 32'(err), 32'b100);
    check("t3_gid", 32'(grant_id), 32'd2);
    check("t3_send", 32'(m_send), 32'd0);
    check("t3_active", 32'(active), 32'd0);
    req = '0;
    @(negedge clk);
    check("t3_err_pulse", 32'(err), 32'd0);
    check("t3_send_after", 32'(m_send), 32'd0);

    // 2: all requesting; ptr wrapped to 0 so order is 0,1,2,0
    req_ss   = {3'd3, 3'd2, 3'd1};
    req_data = {20'h33333, 20'h22222, 20'h11111};
    req      = 3'b111;
    serve(0, 3'd1, 20'h11111, 20'hEEEEE, 1'b0, waited);
    serve(1, 3'd2, 20'h22222, 20'hDDDDD, 1'b0, waited);
    check("t2_done_to_ack", 32'(waited), 32'd2);
    serve(2, 3'd3, 20'h33333, 20'hCCCCC, 1'b0, waited);
    serve(0, 3'd1, 20'h11111, 20'hEEEEE, 1'b1, waited);
    @(negedge clk);

    // 4: busy never rises -> timeout after exactly TIMEOUT send cycles
    req_ss   = {3'd0, 3'd0, 3'd1};
    req_data = {20'h0, 20'h0, 20'h0BEEF};
    req      = 3'b001;
    wait_ack(waited);
    check("t4_ack", 32'(ack), 32'b001);
    req = '0;
    hi  = 0;
    for (int c = 0; c < 200; c++) begin
      if (!m_send) break;
      hi++;
      @(negedge clk);
    end
    check("t4_send_cycles", 32'(hi), 32'(TIMEOUT));
    check("t4_err", 32'(err), 32'b001);
    check("t4_no_done", 32'(done), 32'd0);
    check("t4_active", 32'(active), 32'd0);
    @(negedge clk);
    check("t4_err_pulse", 32'(err), 32'd0);

    // 6: master busy in IDLE blocks the grant
    busy     = 1'b1;
    req_data = {20'h0, 20'h0, 20'h00777};
    req      = 3'b001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_ack", 32'(ack), 32'd0);
    end
    busy = 1'b0;
    serve(0, 3'd1, 20'h00777, 20'hFF888, 1'b1, waited);
    check("t6_ack_next_edge", 32'(waited), 32'd1);
    @(negedge clk);

    // 5: reset during WAIT
    req_ss   = {3'd0, 3'd0, 3'd3};
    req_data = {20'h0, 20'h0, 20'h0F0F0};
    req      = 3'b001;
    wait_ack(waited);
    check("t5_ack", 32'(ack), 32'b001);
    req  = '0;
    busy = 1'b1;
    @(negedge clk);
    check("t5_in_wait", 32'(active), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_active", 32'(active), 32'd0);
    check("t5_rst_ss", 32'(m_ss), 32'd0);
    check("t5_rst_data", 32'(m_dout), 32'd0);
    check("t5_rst_rdata", 32'(rdata), 32'd0);
    check("t5_rst_gid", 32'(grant_id), 32'd0);
    busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
    end
    req_ss   = {3'd0, 3'd0, 3'd1};
    req_data = {20'h0, 20'h0, 20'h12345};
    req      = 3'b001;
    serve(0, 3'd1, 20'h12345, 20'hEDCBA, 1'b1, waited);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
